// File: rtl/tmr_voter_top.sv
// Voted-voter TMR stage: three redundant majority voters feed a final majority
// vote. The result and per-copy/per-voter error flags are registered.

module tmr_voter_maj #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] voted_data
);

  assign voted_data = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);

endmodule

module tmr_voter_top #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_1,
  input  logic [WIDTH-1:0]     data_2,
  input  logic [WIDTH-1:0]     data_3,
  output logic [WIDTH-1:0]     tmr_out,
  output logic [2:0]           in_err,
  output logic [2:0]           voter_err,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] err_count
);

  logic [WIDTH-1:0] vote_1, vote_2, vote_3;
  logic [WIDTH-1:0] final_vote;
  logic [2:0]       in_err_next;
  logic [2:0]       voter_err_next;
  logic             mismatch_next;

  // Three physically separate voters; a fault in any one is outvoted below.
  tmr_voter_maj #(.WIDTH(WIDTH)) voter_1 (
    .data_1(data_1), .data_2(data_2), .data_3(data_3), .voted_data(vote_1)
  );
  tmr_voter_maj #(.WIDTH(WIDTH)) voter_2 (
    .data_1(data_1), .data_2(data_2), .data_3(data_3), .voted_data(vote_2)
  );
  tmr_voter_maj #(.WIDTH(WIDTH)) voter_3 (
    .data_1(data_1), .data_2(data_2), .data_3(data_3), .voted_data(vote_3)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    final_vote     = (vote_1 & vote_2) | (vote_1 & vote_3) | (vote_2 & vote_3);
    in_err_next    = '0;
    voter_err_next = '0;
    in_err_next[0]    = (data_1 != final_vote);
    in_err_next[1]    = (data_2 != final_vote);
    in_err_next[2]    = (data_3 != final_vote);
    voter_err_next[0] = (vote_1 != final_vote);
    voter_err_next[1] = (vote_2 != final_vote);
    voter_err_next[2] = (vote_3 != final_vote);
    mismatch_next     = (|in_err_next) | (|voter_err_next);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_out   <= '0;
      in_err    <= '0;
      voter_err <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      tmr_out   <= final_vote;
      in_err    <= in_err_next;
      voter_err <= voter_err_next;
      mismatch  <= mismatch_next;
      // Saturate rather than wrap so a long fault burst is never hidden.
      if (mismatch_next && (err_count != {CNT_WIDTH{1'b1}}))
        err_count <= err_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_tmr_voter_top.sv
// Randomized and directed bench for tmr_voter_top with voter fault injection,
// checked against a bit-counting majority reference model.

module tb_tmr_voter_top;

  localparam int WIDTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [WIDTH-1:0]     data_1, data_2, data_3;
  logic [WIDTH-1:0]     tmr_out;
  logic [2:0]           in_err;
  logic [2:0]           voter_err;
  logic                 mismatch;
  logic [CNT_WIDTH-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Fault injection state, mirrored by the reference model.
  logic             f_en [3];
  logic [WIDTH-1:0] f_val [3];
  logic [WIDTH-1:0] fv1, fv2, fv3;
  int               exp_count;

  tmr_voter_top #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .tmr_out(tmr_out), .in_err(in_err), .voter_err(voter_err),
    .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Majority by counting ones per bit position.
  function automatic logic [WIDTH-1:0] ref_maj(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int ones;
      ones = 0;
      if (a[i]) ones++;
      if (b[i]) ones++;
      if (c[i]) ones++;
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic set_fault(input int idx, input logic [WIDTH-1:0] v);
    f_en[idx]  = 1'b1;
    f_val[idx] = v;
    case (idx)
      0: begin fv1 = v; force dut.voter_1.voted_data = fv1; end
      1: begin fv2 = v; force dut.voter_2.voted_data = fv2; end
      default: begin fv3 = v; force dut.voter_3.voted_data = fv3; end
    endcase
  endtask

  task automatic clear_faults();
    release dut.voter_1.voted_data;
    release dut.voter_2.voted_data;
    release dut.voter_3.voted_data;
    for (int i = 0; i < 3; i++) f_en[i] = 1'b0;
  endtask

  // Apply inputs, clock once, then compare every output against the model.
  task automatic step(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                      input logic [WIDTH-1:0] d3);
    logic [WIDTH-1:0] d [3];
    logic [WIDTH-1:0] v [3];
    logic [WIDTH-1:0] fin;
    logic [2:0]       e_in, e_v;
    logic             e_mis;
    data_1 = d1; data_2 = d2; data_3 = d3;
    d[0] = d1; d[1] = d2; d[2] = d3;
    for (int i = 0; i < 3; i++) v[i] = f_en[i] ? f_val[i] : ref_maj(d1, d2, d3);
    fin = ref_maj(v[0], v[1], v[2]);
    for (int i = 0; i < 3; i++) begin
      e_in[i] = (d[i] != fin);
      e_v[i]  = (v[i] != fin);
    end
    e_mis = (e_in != 3'b000) || (e_v != 3'b000);
    if (e_mis && exp_count < CNT_MAX) exp_count++;
    @(posedge clk);
    #1;
    check("tmr_out",   32'(tmr_out),   32'(fin));
    check("in_err",    32'(in_err),    32'(e_in));
    check("voter_err", 32'(voter_err), 32'(e_v));
    check("mismatch",  32'(mismatch),  32'(e_mis));
    check("err_count", 32'(err_count), 32'(exp_count));
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tmr_out"},   32'(tmr_out),   32'd0);
    check({tag, "_in_err"},    32'(in_err),    32'd0);
    check({tag, "_voter_err"}, 32'(voter_err), 32'd0);
    check({tag, "_mismatch"},  32'(mismatch),  32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin f_en[i] = 1'b0; f_val[i] = '0; end
    fv1 = '0; fv2 = '0; fv3 = '0;
    exp_count = 0;
    data_1 = '0; data_2 = '0; data_3 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);

    // T2: unanimous copies
    step(4'b1101, 4'b1101, 4'b1101);
    check("t2_tmr", 32'(tmr_out), 32'hD);
    // T3: copy 3 wrong
    step(4'b1100, 4'b1100, 4'b1001);
    check("t3_in_err", 32'(in_err), 32'b100);
    check("t3_count",  32'(err_count), 32'd1);
    // T4: faulty voter_1 then voter_2
    set_fault(0, 4'b1110);
    step(4'b1000, 4'b1110, 4'b1000);
    check("t4a_tmr", 32'(tmr_out), 32'h8);
    check("t4a_verr", 32'(voter_err), 32'b001);
    clear_faults();
    set_fault(1, 4'b1110);
    step(4'b1110, 4'b1011, 4'b1011);
    check("t4b_tmr", 32'(tmr_out), 32'hB);
    check("t4b_in_err", 32'(in_err), 32'b001);
    clear_faults();
    // T5: faulty voter_3, then release
    set_fault(2, 4'b0100);
    step(4'b1000, 4'b1110, 4'b1110);
    check("t5a_verr", 32'(voter_err), 32'b100);
    clear_faults();
    step(4'b1111, 4'b1110, 4'b1111);
    check("t5b_in_err", 32'(in_err), 32'b010);
    check("t5b_verr",   32'(voter_err), 32'b000);
    step(4'b0110, 4'b0110, 4'b0110);

    // Randomized copies with occasional single-copy corruption and voter faults.
    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] base, c1, c2, c3;
      base = WIDTH'($urandom);
      c1 = base; c2 = base; c3 = base;
      case ($urandom_range(0, 4))
        0: c1 = base ^ WIDTH'($urandom);
        1: c2 = base ^ WIDTH'($urandom);
        2: c3 = base ^ WIDTH'($urandom);
        3: begin c1 = WIDTH'($urandom); c2 = WIDTH'($urandom); c3 = WIDTH'($urandom); end
        default: ;
      endcase
      clear_faults();
      if ($urandom_range(0, 3) == 0) set_fault($urandom_range(0, 2), WIDTH'($urandom));
      step(c1, c2, c3);
    end
    clear_faults();

    // T1: asynchronous reset in mid-cycle clears everything immediately.
    step(4'b0011, 4'b0011, 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // T6: sustained mismatch saturates the counter.
    for (int n = 0; n < (1 << CNT_WIDTH) + 5; n++)
      step(4'b1100, 4'b1100, 4'b1001);
    check("t6_sat", 32'(err_count), 32'(CNT_MAX));
    step(4'b0101, 4'b0101, 4'b0101);
    check("t6_hold", 32'(err_count), 32'(CNT_MAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
